// File: rtl/imem_arbiter_pkg.sv
// Shared CPU control constants: instruction-memory arbiter state
// encoding and default program-memory geometry.
package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RESTART = 2'd2
  } arb_state_t;

  localparam int IMEM_ADDR_W     = 14;
  localparam int IMEM_LOAD_WORDS = 16384;

endpackage

// File: rtl/imem_arbiter.sv
// Shares the instruction memory between the fetch stage and the
// program loader, holding the CPU while a load session is open.
import imem_arbiter_pkg::*;

module imem_arbiter #(
  parameter int ADDR_W     = IMEM_ADDR_W,
  parameter int LOAD_WORDS = IMEM_LOAD_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_inst,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_end,
  output logic              ld_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(LOAD_WORDS);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic            accept;
  logic [ADDR_W:0] cnt_nxt;

  assign fetch_inst = mem_rdata;
  assign accept     = ld_valid & ld_ready;
  assign cnt_nxt    = load_count + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN: begin
        if (ld_start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // the last word and ld_end may coincide
        if (ld_end || (accept && cnt_nxt == LIMIT))
          state_nxt = ST_RESTART;
      end
      ST_RESTART: state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    mem_addr    = fetch_addr;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    ld_ready    = 1'b0;
    cpu_hold    = 1'b0;
    cpu_restart = 1'b0;
    unique case (state)
      ST_RUN: begin
        mem_addr = fetch_addr;
      end
      ST_LOAD: begin
        cpu_hold  = 1'b1;
        ld_ready  = (load_count < LIMIT);
        mem_addr  = load_count[ADDR_W-1:0];
        mem_wdata = ld_data;
        mem_we    = ld_valid & (load_count < LIMIT);
      end
      ST_RESTART: begin
        cpu_hold    = 1'b1;
        cpu_restart = 1'b1;
        mem_addr    = '0;
      end
      default: begin
        mem_addr = fetch_addr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count <= '0;
    end else if (state == ST_RUN && ld_start) begin
      load_count <= '0;
    end else if (state == ST_LOAD && accept) begin
      load_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized and directed bench for imem_arbiter against a
// session-level model of the loader protocol.
module tb_imem_arbiter;

  localparam int AW = 6;
  localparam int LW = 4;
  localparam int MW = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [31:0]   fetch_inst;
  logic          ld_start = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_end = 1'b0;
  logic          ld_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          cpu_hold;
  logic          cpu_restart;
  logic [AW:0]   load_count;

  imem_arbiter #(.ADDR_W(AW), .LOAD_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_inst(fetch_inst),
    .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_end(ld_end),
    .ld_ready(ld_ready), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold),
    .cpu_restart(cpu_restart), .load_count(load_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [MW];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Session model: loading flag, pending restart, words taken
  bit          in_load;
  bit          restart;
  int          cnt;
  logic [31:0] ref_mem [MW];
  logic [31:0] exp_rd;
  bit          rd_known;
  int          n_restart;

  task automatic cycle();
    bit          e_ready;
    bit          e_we;
    int          e_addr;
    @(negedge clk);
    e_ready = in_load && cnt < LW;
    e_we    = e_ready && ld_valid;
    e_addr  = restart ? 0 : (in_load ? cnt : int'(fetch_addr));
    check("hold", cpu_hold, in_load || restart);
    check("restart", cpu_restart, restart);
    check("ready", ld_ready, e_ready);
    check("we", mem_we, e_we);
    check("addr", mem_addr, e_addr);
    check("count", load_count, cnt);
    if (e_we) check("wdata", mem_wdata, ld_data);
    if (rd_known) check("inst", fetch_inst, exp_rd);
    @(posedge clk);
    exp_rd   = ref_mem[e_addr];
    rd_known = 1'b1;
    if (e_we) ref_mem[e_addr] = ld_data;
    if (rst) begin
      if (restart) begin
        restart = 1'b0;
        n_restart++;
      end else if (in_load) begin
        if (e_we) cnt++;
        if (ld_end || cnt == LW) begin
          in_load = 1'b0;
          restart = 1'b1;
        end
      end else if (ld_start) begin
        in_load = 1'b1;
        cnt     = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_end   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_we", mem_we, 1'b0);
    check("rst_ready", ld_ready, 1'b0);
    check("rst_hold", cpu_hold, 1'b0);
    check("rst_restart", cpu_restart, 1'b0);
    check("rst_count", load_count, 0);
    in_load = 1'b0;
    restart = 1'b0;
    cnt     = 0;
    idle();
    cycle();
    rst = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input bit e);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_end   = e;
    cycle();
    idle();
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    cycle();
    idle();
  endtask

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h00500093;
    prog[1] = 32'h00100113;
    prog[2] = 32'h002081B3;
    for (int i = 0; i < MW; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    in_load = 0; restart = 0; cnt = 0;
    rd_known = 0; n_restart = 0;
    #2;
    check("init_hold", cpu_hold, 1'b0);
    check("init_count", load_count, 0);
    @(posedge clk); #1;
    do_reset();

    // fetch pass-through
    for (int a = 0; a < 3; a++) begin
      fetch_addr = AW'(a);
      cycle();
    end
    cycle();

    // three-word program
    start_load();
    for (int i = 0; i < 3; i++) send(prog[i], 1'b0);
    ld_end = 1'b1;
    cycle();
    idle();
    cycle();
    cycle();
    check("prog_count", load_count, 3);
    for (int i = 0; i < 3; i++)
      check("prog_mem", mem[i], prog[i]);
    check("prog_restarts", n_restart, 1);

    // overrun: six words, only LW land
    start_load();
    for (int i = 0; i < 6; i++) send(32'hA000_0000 + i, 1'b0);
    check("ovr_count", load_count, LW);
    check("ovr_mem4", mem[LW], ref_mem[LW]);
    cycle();

    // ld_end together with the second word
    start_load();
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b1);
    cycle();
    check("end_count", load_count, 2);
    check("end_mem1", mem[1], 32'h2222_2222);

    // reset after two of five words
    n_restart = 0;
    start_load();
    send(32'hB000_0000, 1'b0);
    send(32'hB000_0001, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 32'hB000_0002;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hB000_0003 + i;
      cycle();
    end
    idle();
    check("rst_mem2", mem[2], ref_mem[2]);
    check("rst_norestart", n_restart, 0);

    // ld_start inside LOAD, ld_valid in RUN
    start_load();
    send(32'hC000_0000, 1'b0);
    ld_start = 1'b1;
    cycle();
    idle();
    check("restart_ign", load_count, 1);
    send(32'hC000_0001, 1'b1);
    cycle();
    cycle();
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    cycle();
    idle();
    check("run_valid", load_count, 2);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        fetch_addr = AW'($urandom);
        ld_start   = ($urandom_range(0, 19) == 0);
        ld_valid   = $urandom_range(0, 1) == 1;
        ld_end     = ($urandom_range(0, 9) == 0);
        ld_data    = $urandom;
        cycle();
      end
    end
    idle();
    cycle();
    for (int i = 0; i < MW; i++)
      check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
